// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - UART framed-image loader into imem; holds core in reset until loaded
// Optional trailing XOR checksum byte enabled by defining UART_BOOT_CSUM_EN.
module uart_boot_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 12,
  parameter int MAX_WORDS    = 4096
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              uart_rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset_n,
  output logic              boot_done,
  output logic              boot_error
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [16:0]      MAX_LEN  = 17'(MAX_WORDS);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LEN0, ST_LEN1, ST_DATA,
`ifdef UART_BOOT_CSUM_EN
    ST_CSUM,
`endif
    ST_DONE, ST_ERROR
  } state_t;

`ifdef UART_BOOT_CSUM_EN
  localparam state_t ST_AFTER_DATA = ST_CSUM;
`else
  localparam state_t ST_AFTER_DATA = ST_DONE;
`endif

  // ---------------- UART receiver ----------------
  logic             rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_ferr_q, rx_ferr_d;
  logic             rx_tick, rx_half;

  assign rx_tick = (rx_cnt_q == BIT_END);
  assign rx_half = (rx_cnt_q == HALF_END);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_s1_q    <= uart_rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      RX_IDLE:  if (rx_prev_q && !rx_s2_q) rx_state_d = RX_START;
      RX_START: if (rx_half) rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      RX_STOP:  if (rx_tick) rx_state_d = RX_IDLE;
      default:  rx_state_d = RX_IDLE;
    endcase
  end

  // Byte stays in rx_shift_q while rx_valid_q is high and long after.
  always_comb begin
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
      end
      RX_START: if (rx_half) rx_cnt_d = '0;
      RX_DATA: if (rx_tick) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 3'd1;
      end
      RX_STOP: if (rx_tick) begin
        rx_cnt_d   = '0;
        rx_valid_d = rx_s2_q;
        rx_ferr_d  = !rx_s2_q;
      end
      default: rx_cnt_d = '0;
    endcase
  end

  // ---------------- Frame parser / loader ----------------
  state_t            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       word_idx_q, word_idx_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       word_q, word_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              core_rst_q, core_rst_d;
  logic [15:0]       len_rx;
  logic              last_byte;
`ifdef UART_BOOT_CSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  assign len_rx    = {rx_shift_q, len_lo_q};
  assign last_byte = (byte_cnt_q == 2'd3) && (word_idx_q == len_q - 16'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      len_lo_q     <= '0;
      len_q        <= '0;
      word_idx_q   <= '0;
      byte_cnt_q   <= '0;
      word_q       <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_rst_q   <= 1'b0;
`ifdef UART_BOOT_CSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      len_q        <= len_d;
      word_idx_q   <= word_idx_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_rst_q   <= core_rst_d;
`ifdef UART_BOOT_CSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  // DONE and ERROR are terminal: once loaded the line is ignored until reset.
  always_comb begin
    state_d = state_q;
    if (rx_ferr_q && state_q != ST_DONE) begin
      state_d = ST_ERROR;
    end else if (rx_valid_q) begin
      case (state_q)
        ST_IDLE: if (rx_shift_q == 8'h55) state_d = ST_LEN0;
        ST_LEN0: state_d = ST_LEN1;
        ST_LEN1: begin
          if ({1'b0, len_rx} > MAX_LEN) state_d = ST_ERROR;
          else if (len_rx == 16'd0)     state_d = ST_AFTER_DATA;
          else                          state_d = ST_DATA;
        end
        ST_DATA: if (last_byte) state_d = ST_AFTER_DATA;
`ifdef UART_BOOT_CSUM_EN
        ST_CSUM: state_d = (rx_shift_q == csum_q) ? ST_DONE : ST_ERROR;
`endif
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    len_lo_d     = len_lo_q;
    len_d        = len_q;
    word_idx_d   = word_idx_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    core_rst_d   = (state_q == ST_DONE);
`ifdef UART_BOOT_CSUM_EN
    csum_d       = csum_q;
`endif
    if (rx_valid_q) begin
      case (state_q)
        ST_LEN0: len_lo_d = rx_shift_q;
        ST_LEN1: begin
          len_d      = len_rx;
          word_idx_d = '0;
          byte_cnt_d = '0;
        end
        ST_DATA: begin
          word_d     = {rx_shift_q, word_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef UART_BOOT_CSUM_EN
          csum_d     = csum_q ^ rx_shift_q;
`endif
          if (byte_cnt_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_idx_q[ADDR_W-1:0];
            imem_wdata_d = word_d;
            word_idx_d   = word_idx_q + 16'd1;
          end
        end
        default: len_lo_d = len_lo_q;
      endcase
    end
  end

  always_comb begin
    boot_done  = (state_q == ST_DONE);
    boot_error = (state_q == ST_ERROR);
  end

  assign imem_we      = imem_we_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign core_reset_n = core_rst_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb/tb_uart_boot_loader.sv - directed bench for uart_boot_loader
module tb_uart_boot_loader;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic        imem_we;
  logic [3:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_reset_n;
  logic        boot_done;
  logic        boot_error;

  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  logic [31:0] wr_addr [16];
  logic [31:0] wr_data [16];
  logic [7:0]  tx_q [$];

  uart_boot_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(4), .MAX_WORDS(8)) dut (
    .clk(clk), .reset_n(reset_n), .uart_rx(uart_rx),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_reset_n(core_reset_n), .boot_done(boot_done), .boot_error(boot_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset_n) begin
      wr_cnt <= 0;
    end else if (imem_we) begin
      if (wr_cnt < 16) begin
        wr_addr[wr_cnt] <= 32'(imem_addr);
        wr_data[wr_cnt] <= imem_wdata;
      end
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_q();
    while (tx_q.size() > 0) send_byte(tx_q.pop_front(), 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    uart_rx = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(boot_done || boot_error) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("end_reached", 32'(boot_done | boot_error), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_core", 32'(core_reset_n), 32'd0);
    check("rst_done", 32'(boot_done), 32'd0);
    check("rst_err", 32'(boot_error), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // two-word image
    tx_q = {8'h55, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
`ifdef UART_BOOT_CSUM_EN
    tx_q.push_back(8'h90);
`endif
    send_q();
    wait_end();
    check("t1_done", 32'(boot_done), 32'd1);
    check("t1_core_lag", 32'(core_reset_n), 32'd0);
    @(negedge clk);
    check("t1_core_up", 32'(core_reset_n), 32'd1);
    repeat (2) @(negedge clk);
    check("t1_wr_cnt", 32'(wr_cnt), 32'd2);
    check("t1_a0", wr_addr[0], 32'd0);
    check("t1_d0", wr_data[0], 32'h00000013);
    check("t1_a1", wr_addr[1], 32'd1);
    check("t1_d1", wr_data[1], 32'h00100093);
    check("t1_hold_addr", 32'(imem_addr), 32'd1);
    check("t1_hold_data", imem_wdata, 32'h00100093);
    send_byte(8'h00, 1'b0);
    repeat (4) @(negedge clk);
    check("t1_ignore_err", 32'(boot_error), 32'd0);
    check("t1_ignore_done", 32'(boot_done), 32'd1);

    // junk before header
    do_reset();
    check("t2_rst_done", 32'(boot_done), 32'd0);
    tx_q = {8'hAA, 8'h00, 8'h55, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef UART_BOOT_CSUM_EN
    tx_q.push_back(8'h22);
`endif
    send_q();
    wait_end();
    repeat (3) @(negedge clk);
    check("t2_done", 32'(boot_done), 32'd1);
    check("t2_wr_cnt", 32'(wr_cnt), 32'd1);
    check("t2_a0", wr_addr[0], 32'd0);
    check("t2_d0", wr_data[0], 32'hDEADBEEF);

    // length above MAX_WORDS
    do_reset();
    tx_q = {8'h55, 8'h09, 8'h00};
    send_q();
    wait_end();
    repeat (10) @(negedge clk);
    check("t3_err", 32'(boot_error), 32'd1);
    check("t3_done", 32'(boot_done), 32'd0);
    check("t3_wr_cnt", 32'(wr_cnt), 32'd0);
    check("t3_core", 32'(core_reset_n), 32'd0);

    // zero-length image
    do_reset();
    tx_q = {8'h55, 8'h00, 8'h00};
`ifdef UART_BOOT_CSUM_EN
    tx_q.push_back(8'h00);
`endif
    send_q();
    wait_end();
    repeat (3) @(negedge clk);
    check("t4_done", 32'(boot_done), 32'd1);
    check("t4_core", 32'(core_reset_n), 32'd1);
    check("t4_wr_cnt", 32'(wr_cnt), 32'd0);

    // framing error mid-word
    do_reset();
    tx_q = {8'h55, 8'h01, 8'h00, 8'h11};
    send_q();
    send_byte(8'h22, 1'b0);
    wait_end();
    repeat (10) @(negedge clk);
    check("t5_err", 32'(boot_error), 32'd1);
    check("t5_wr_cnt", 32'(wr_cnt), 32'd0);
    check("t5_core", 32'(core_reset_n), 32'd0);

    // reset during payload, then a clean frame
    do_reset();
    tx_q = {8'h55, 8'h01, 8'h00, 8'hAA, 8'hBB};
    send_q();
    do_reset();
    check("t6_err_clear", 32'(boot_error), 32'd0);
    tx_q = {8'h55, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
`ifdef UART_BOOT_CSUM_EN
    tx_q.push_back(8'h08);
`endif
    send_q();
    wait_end();
    repeat (3) @(negedge clk);
    check("t6_done", 32'(boot_done), 32'd1);
    check("t6_wr_cnt", 32'(wr_cnt), 32'd1);
    check("t6_a0", wr_addr[0], 32'd0);
    check("t6_d0", wr_data[0], 32'h12345678);

`ifdef UART_BOOT_CSUM_EN
    do_reset();
    tx_q = {8'h55, 8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0F};
    send_q();
    wait_end();
    repeat (3) @(negedge clk);
    check("c1_done", 32'(boot_done), 32'd1);
    check("c1_d0", wr_data[0], 32'h08040201);

    do_reset();
    tx_q = {8'h55, 8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0E};
    send_q();
    wait_end();
    repeat (3) @(negedge clk);
    check("c2_err", 32'(boot_error), 32'd1);
    check("c2_wr_cnt", 32'(wr_cnt), 32'd1);
    check("c2_d0", wr_data[0], 32'h08040201);
    check("c2_core", 32'(core_reset_n), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
